// File: rtl/swap_pkg.sv
// swap_pkg: FSM state type and default sizing shared by the swap request queue files.
package swap_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   localparam int ADDR_W_DEF = 4;
   localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/swap_req_fifo.sv
// swap_req_fifo: address-pair FIFO with wrapping pointers and an occupancy count.
module swap_req_fifo
   import swap_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [ADDR_W-1:0]        i_a,
   input  logic [ADDR_W-1:0]        i_b,
   output logic [ADDR_W-1:0]        o_head_a,
   output logic [ADDR_W-1:0]        o_head_b,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [ADDR_W-1:0] r_mem_a [DEPTH];
   logic [ADDR_W-1:0] r_mem_b [DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic w_push, w_pop;
   assign o_full = (r_count == CW'(DEPTH));
   assign w_push = i_push && !o_full;
   assign w_pop = i_pop && (r_count != '0);
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wptr] <= i_a;
         r_mem_b[r_wptr] <= i_b;
      end
   end
   assign o_head_a = r_mem_a[r_rptr];
   assign o_head_b = r_mem_b[r_rptr];
   assign o_count = r_count;
endmodule

// File: rtl/swap_request_queue.sv
// swap_request_queue: queues address pairs and sequences them through an external swap controller.
// Optional SWAP_SKIP_SAME_EN retires equal-address entries without issuing a swap.
module swap_request_queue
   import swap_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_W-1:0]        req_a,
   input  logic [ADDR_W-1:0]        req_b,
   input  logic                     swap_w,
   output logic                     swap,
   output logic [ADDR_W-1:0]        addr_a,
   output logic [ADDR_W-1:0]        addr_b,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count
);
   state_t r_state, w_next;
   logic r_done;
   logic [ADDR_W-1:0] r_la, r_lb, w_head_a, w_head_b;
   logic [$clog2(DEPTH):0] w_count;
   logic w_full, w_pop, w_skip, w_nonempty;
   swap_req_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .i_push(req_valid && req_ready),
      .i_pop(w_pop),
      .i_a(req_a),
      .i_b(req_b),
      .o_head_a(w_head_a),
      .o_head_b(w_head_b),
      .o_count(w_count),
      .o_full(w_full)
   );
   assign w_nonempty = (w_count != '0);
`ifdef SWAP_SKIP_SAME_EN
   assign w_skip = (r_state == IDLE) && w_nonempty && (w_head_a == w_head_b);
`else
   assign w_skip = 1'b0;
`endif
   assign w_pop = ((r_state == WAIT) && !swap_w) || w_skip;
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = (w_nonempty && !swap_w && !w_skip) ? ISSUE : IDLE;
         ISSUE:   w_next = WAIT;
         WAIT:    w_next = swap_w ? WAIT : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_done <= 1'b0;
         r_la <= '0;
         r_lb <= '0;
      end else begin
         r_state <= w_next;
         r_done <= w_pop;
         if (w_pop) begin
            r_la <= w_head_a;
            r_lb <= w_head_b;
         end
      end
   end
   // the retired pair stays visible during the done cycle even though it has left the queue
   assign addr_a = r_done ? r_la : (w_nonempty ? w_head_a : '0);
   assign addr_b = r_done ? r_lb : (w_nonempty ? w_head_b : '0);
   assign swap = (r_state == ISSUE);
   assign busy = (r_state != IDLE);
   assign done = r_done;
   assign count = w_count;
   assign req_ready = !w_full;
endmodule

// File: tb/tb_swap_request_queue.sv
// tb_swap_request_queue: randomized bench with a queue scoreboard and a downstream swap controller model.
`timescale 1ns/1ps
module tb_swap_request_queue;
   localparam int ADDR_W = 4;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH) + 1;
`ifdef SWAP_SKIP_SAME_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
   } ent_t;
   logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, swap_w = 1'b0;
   logic req_ready, swap, busy, done;
   logic [ADDR_W-1:0] req_a = '0, req_b = '0, addr_a, addr_b;
   logic [CW-1:0] count;
   ent_t q[$];
   int checks = 0, errors = 0, cyc = 0;

   swap_request_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a(req_a),
      .req_b(req_b),
      .swap_w(swap_w),
      .swap(swap),
      .addr_a(addr_a),
      .addr_b(addr_b),
      .busy(busy),
      .done(done),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // one stimulus cycle; acceptance is known here because req_ready only changes at clk edges
   task automatic drive(input bit r, input bit v, input ent_t e, output bit acc);
      @(negedge clk);
      #1;
      reset = r;
      req_valid = v;
      req_a = e.a;
      req_b = e.b;
      acc = v && req_ready && !r;
      if (acc) q.push_back(e);
   endtask

   function automatic ent_t rand_ent();
      ent_t e;
      e.a = ADDR_W'($urandom);
      e.b = ($urandom_range(0, 3) == 0) ? e.a : ADDR_W'($urandom);
      return e;
   endfunction

   // monitor and downstream controller: the controller holds swap_w for n cycles after each swap
   initial begin : mon
      ent_t e;
      int n = 0, wcnt = 0, done_at = -1, nsw = 0;
      bit in_flight = 0, exp_swap = 0, exp_skip = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            chk("rst_count", count, 0);
            chk("rst_swap", swap, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_addr_a", addr_a, 0);
            chk("rst_addr_b", addr_b, 0);
            chk("rst_ready", req_ready, 1);
            q.delete();
            in_flight = 0;
            wcnt = 0;
            done_at = -1;
            exp_swap = 0;
            exp_skip = 0;
         end else begin
            chk("swap", swap, exp_swap);
            if (swap) begin
               in_flight = 1;
               n = (nsw == 0) ? 3 : $urandom_range(0, 4);
               nsw++;
               done_at = cyc + n + 2;
            end
            chk("done", done, int'(done_at == cyc || exp_skip));
            if (done) begin
               in_flight = 0;
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk("done_addr_a", addr_a, e.a);
                  chk("done_addr_b", addr_b, e.b);
               end else chk("done_with_empty_model", 1, 0);
            end else begin
               e = (q.size() > 0) ? q[0] : ent_t'('0);
               chk("addr_a", addr_a, e.a);
               chk("addr_b", addr_b, e.b);
            end
            chk("count", count, q.size());
            chk("ready", req_ready, int'(q.size() < DEPTH));
            chk("busy", busy, in_flight);
         end
         if (wcnt > 0) begin
            swap_w = 1'b1;
            wcnt--;
         end else swap_w = in_flight ? 1'b0 : ($urandom_range(0, 2) == 0);
         if (!reset && swap) wcnt = n;
         exp_skip = !in_flight && q.size() > 0 && SKIP && q[0].a == q[0].b;
         exp_swap = !in_flight && q.size() > 0 && !swap_w && !exp_skip;
      end
   end

   initial begin : stim
      ent_t e;
      bit acc;
      int got, k;
      int prob [6] = '{100, 70, 40, 20, 90, 10};
      e = '0;
      repeat (3) drive(1'b1, 1'b0, e, acc);
      e.a = 4'd3;
      e.b = 4'd9;
      drive(1'b0, 1'b1, e, acc);
      chk("first_push_accepted", acc, 1);
      repeat (25) drive(1'b0, 1'b0, e, acc);
      got = 0;
      k = 0;
      e = rand_ent();
      while (got < 5 && k < 200) begin
         drive(1'b0, 1'b1, e, acc);
         if (acc) begin
            got++;
            e = rand_ent();
         end
         k++;
      end
      chk("burst_all_accepted", got, 5);
      repeat (60) drive(1'b0, 1'b0, e, acc);
      e = rand_ent();
      e.b = ~e.a;
      drive(1'b0, 1'b1, e, acc);
      k = 0;
      while (!busy && k < 50) begin
         drive(1'b0, 1'b0, e, acc);
         k++;
      end
      chk("busy_seen_before_reset", busy, 1);
      drive(1'b0, 1'b0, e, acc);
      drive(1'b1, 1'b0, e, acc);
      for (int s = 0; s < 6; s++) begin
         for (int c = 0; c < 400; c++) begin
            e = rand_ent();
            drive($urandom_range(0, 249) == 0, $urandom_range(1, 100) <= prob[s], e, acc);
         end
      end
      repeat (150) drive(1'b0, 1'b0, e, acc);
      chk("drain_count", count, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/swap_request_queue.md
SWAP_REQUEST_QUEUE -- requirements
Module: swap_request_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter ADDR_W SHALL default to 4 and SHALL be the width of each swap address.
REQ-003 Parameter DEPTH SHALL default to 4, SHALL be a power of two, SHALL be at least 2, and SHALL be the request queue depth.
REQ-004 Ports SHALL be as follows:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  swap request offered.
- req_ready  out  1  queue can accept a request.
- req_a  in  ADDR_W  first address of the pair.
- req_b  in  ADDR_W  second address of the pair.
- swap_w  in  1  write/busy flag from the downstream swap controller.
- swap  out  1  one-cycle start pulse to the swap controller.
- addr_a  out  ADDR_W  head-of-queue address A.
- addr_b  out  ADDR_W  head-of-queue address B.
- busy  out  1  a swap is in flight.
- done  out  1  one-cycle completion pulse.
- count  out  log2(DEPTH)+1  number of queued entries, including the in-flight entry.

Function
REQ-005 A push SHALL occur when req_valid and req_ready are both high at a clk edge; req_ready SHALL be (count < DEPTH).
REQ-006 Entries SHALL be served in FIFO order, and the head entry SHALL stay queued until its swap completes.
REQ-007 The control FSM SHALL have exactly three states:
- IDLE, the reset state.
- ISSUE.
- WAIT.
REQ-008 In IDLE, the FSM SHALL move to ISSUE when count > 0 and swap_w = 0; otherwise it SHALL remain in IDLE.
REQ-009 swap SHALL be high exactly while the FSM is in ISSUE, and ISSUE SHALL always last one cycle before moving to WAIT.
REQ-010 In WAIT, the FSM SHALL stay while swap_w = 1. When swap_w = 0 is sampled, at that edge it SHALL pop the head, set done high for the next cycle, and move to IDLE.
REQ-011 Nominal timing, with the downstream controller asserting w for 3 cycles:
- ISSUE at cycle t.
- swap_w high for t+1..t+3.
- done high at t+5.
- Next ISSUE no earlier than t+5.
REQ-012 addr_a and addr_b SHALL show the head entry whenever count > 0 and SHALL stay constant from ISSUE through the done cycle; when count = 0 they SHALL be 0.
REQ-013 busy SHALL be high in ISSUE and WAIT and low in IDLE.
REQ-014 A simultaneous push and pop SHALL leave count unchanged, and both operations SHALL take effect.
REQ-015 When the queue is full, req_ready SHALL be low and an offered request SHALL be neither stored nor lost. A pop in the same cycle SHALL NOT raise req_ready combinationally.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-017 While reset is high at a clk edge:
- The FSM SHALL go to IDLE and the queue SHALL be emptied.
- Outputs SHALL be: count = 0, swap = 0, done = 0, busy = 0, addr_a = 0, addr_b = 0, req_ready = 1.
REQ-018 Reset asserted mid-swap SHALL discard the in-flight entry without a done pulse. After reset, the block SHALL not issue until swap_w = 0.

Configuration
REQ-019 With macro SWAP_SKIP_SAME_EN defined, a head entry with req_a == req_b SHALL be retired from IDLE directly: pop at that edge, done high the next cycle, no swap pulse, busy stays low.
REQ-020 Without SWAP_SKIP_SAME_EN, equal-address entries SHALL be issued like any other entry.

Structure
REQ-021 Package swap_pkg SHALL hold the FSM state typedef (IDLE/ISSUE/WAIT) and the default ADDR_W and DEPTH constants.
REQ-022 Queue storage and pointers SHALL be a sub-module swap_req_fifo (push, pop, head, count, full). The FSM SHALL live in swap_request_queue.

Verification
REQ-023 Single request {a=3, b=9} with a downstream model holding w for 3 cycles -> swap=1 for one cycle, addr_a=3 and addr_b=9 held stable, done=1 exactly 5 cycles after ISSUE, count 1 -> 0.
REQ-024 Push 5 requests back-to-back with DEPTH=4 -> req_ready low after the 4th push; the 5th is accepted only after the first done; completions come in push order.
REQ-025 Push on the same edge as a pop with count=2 -> count stays 2 and the new entry appears at the tail.
REQ-026 Reset asserted during WAIT -> next cycle count=0, busy=0, no done pulse; new requests are served normally afterwards.
REQ-027 Request {a=5, b=5} -> with SWAP_SKIP_SAME_EN: done one cycle after reaching the head and swap never asserted; without it: a normal swap sequence.
REQ-028 Hold swap_w=1 externally while idle with count=1 -> no ISSUE until swap_w drops; then ISSUE on the following cycle.
